// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - controller <-> datapath signal bundle
//
// Purpose: groups the instruction/flag inputs and the datapath control outputs
//          of the multicycle sequencer into one bundle.
// Signals:
//   Instr[31:0]     instruction-register word from the datapath
//   ALUFlags[3:0]   live ALU flags {N,Z,C,V}
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite       enables / selects
//   ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0], ALUControl[1:0]
//   ImmSrc[1:0], RegSrc[1:0]                           decode outputs
//   Flags[3:0]      registered NZCV
//   State[3:0]      current sequencer state (debug)
// Modports: master = controller side, slave = datapath side.
interface multicycle_control_unit_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [3:0]  Flags;
  logic [3:0]  State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, Flags, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, Flags, State
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle ARM-subset sequencing controller
//
// Purpose: decodes the instruction-register word and steps a state machine
//          that drives datapath selects, ALU operation and write enables
//          (2-5 cycles per instruction). Holds NZCV and evaluates conditions.
// Ports:
//   clk    system clock, all state on posedge
//   reset  synchronous, active-high
//   bus    multicycle_control_unit_if.master (Instr/ALUFlags in, controls out)
module multicycle_control_unit (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_control_unit_if.master     bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  flags;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [3:0]  cmd;
  logic        is_cmp;
  logic        set_flags;
  logic        rd_is_pc;
  logic        cond_ex;
  logic [1:0]  dp_alu;

  logic        pc_write;
  logic        adr_src;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  result_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_control;
  logic        reg_write;

  logic        unused_instr_bits;

  assign cond      = bus.Instr[31:28];
  assign op        = bus.Instr[27:26];
  assign funct     = bus.Instr[25:20];
  assign rd        = bus.Instr[15:12];
  assign cmd       = funct[4:1];
  assign is_cmp    = (cmd == 4'b1010);
  assign set_flags = funct[0] | is_cmp;
  assign rd_is_pc  = (rd == 4'd15);

  assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

  // Condition check against the registered flags {N,Z,C,V}.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Data-processing ALU op; CMP is a SUB whose result is discarded.
  always_comb begin
    dp_alu = 2'b00;
    case (cmd)
      4'b0100: dp_alu = 2'b00;
      4'b0010: dp_alu = 2'b01;
      4'b0000: dp_alu = 2'b10;
      4'b1100: dp_alu = 2'b11;
      4'b1010: dp_alu = 2'b01;
      default: dp_alu = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      flags <= 4'b0000;
    end else begin
      state <= next_state;
      if (((state == EXECR) || (state == EXECI)) && set_flags)
        flags <= bus.ALUFlags;
    end
  end

  always_comb begin
    next_state  = FETCH;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 2'b00;
    reg_write   = 1'b0;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        next_state = DECODE;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (!cond_ex || op == 2'b11)
          next_state = FETCH;
        else if (op == 2'b01)
          next_state = MEMADR;
        else if (op == 2'b10)
          next_state = BRANCH;
        else if (funct[5])
          next_state = EXECI;
        else
          next_state = EXECR;
      end
      MEMADR: begin
        alu_src_b  = 2'b01;
        next_state = funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        pc_write   = rd_is_pc;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECR, EXECI: begin
        alu_src_b   = (state == EXECI) ? 2'b01 : 2'b00;
        alu_control = dp_alu;
        next_state  = is_cmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        pc_write  = rd_is_pc;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // Architectural writes are suppressed while reset is held so an abandoned
  // instruction cannot commit anything in the reset cycle.
  assign bus.PCWrite    = pc_write  & ~reset;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.IRWrite    = ir_write  & ~reset;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
  assign bus.Flags      = flags;
  assign bus.State      = state;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequencing controller for the multicycle ARM-subset datapath. Decodes the instruction-register word and walks a state machine that drives the datapath's mux selects, ALU operation and write enables: one instruction every 2–5 cycles. Holds the NZCV flags register and evaluates ARM condition codes. Sits beside the datapath, replacing the single-cycle combinational decoder with a per-cycle sequencer.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- Instr  in  32  instruction-register output from the datapath. Fields used: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12].
- ALUFlags  in  4  live ALU flags {N,Z,C,V} = [3:0].
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  1  0 = RD1, 1 = PC.
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  [0] = (Op==10); [1] = (Op==01 & Funct[0]==0).
- RegWrite  out  1  register file write enable.
- Flags  out  4  registered NZCV.
- State  out  4  current state encoding, for debug and verification.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Unused codes go to FETCH on the next edge.
- Signals not listed for a state are 0.
- **FETCH:** IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD. Next state: DECODE.
- **DECODE:** ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - CondEx computed from Cond and the registered Flags (not ALUFlags).
  - If CondEx=0 or Op=11: next state FETCH (instruction squashed).
  - Else Op=01 → MEMADR; Op=00 with Funct[5]=0 → EXECR; Op=00 with Funct[5]=1 → EXECI; Op=10 → BRANCH.
- **MEMADR:** ALUSrcA=0, ALUSrcB=01, ADD. Next state: MEMREAD if Funct[0]=1, else MEMWRITE.
- **MEMREAD:** AdrSrc=1. Next state: MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1, PCWrite=(Rd==15). Next state: FETCH.
- **MEMWRITE:** AdrSrc=1, MemWrite=1. Next state: FETCH.
- **EXECR / EXECI:** ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl decoded from cmd=Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (uses SUB). Any other cmd uses ADD.
  - Flags ← ALUFlags at the end of the cycle when Funct[0]=1 (S bit) or cmd=CMP.
  - Next state: FETCH for CMP; otherwise ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1, PCWrite=(Rd==15). Next state: FETCH.
- **BRANCH:** ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1. Next state: FETCH.
- **CondEx truth table:**
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V.
  - GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 → 0.

## Timing
- Cycles per instruction: data processing 4 (CMP 3); LDR 5; STR 4; branch 3; squashed or Op=11 2.
- All outputs are a combinational function of State and Instr (Moore plus instruction decode). There is no output register.
- Instr must be stable from DECODE onward. IRWrite is asserted only in FETCH.
- The Flags register updates only on the EXECR/EXECI → next edge. A flag-setting instruction's flags are visible to the next instruction's DECODE.
- **Reset:**
  - While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - On the reset edge, State ← FETCH and Flags ← 0000.
  - Reset asserted mid-instruction abandons it with no write that cycle.
  - The first fetch occurs in the first cycle with reset=0.

## Test plan
- **Immediate ADD:** reset, then Instr=0xE280002A (ADD R0,R0,#42) → State 0,1,7,8,0. In EXECI: ALUSrcB=01, ALUControl=00. RegWrite=1 only in ALUWB. Flags stay 0000.
- **SUBS then BEQ taken:** Instr=0xE2511001 (SUBS) with ALUFlags=0100 in EXECI → Flags=0100. Then Instr=0x0A000002 (BEQ) → State 0,1,9. PCWrite=1 in BRANCH. RegSrc=x1, ImmSrc=10.
- **BEQ squashed:** Flags=0000, Instr=0x0A000002 → State 0,1,0. No PCWrite after FETCH.
- **LDR / STR:**
  - LDR Instr=0xE5902004 → States 0,1,2,3,4. AdrSrc=1 in MEMREAD. ResultSrc=01 and RegWrite=1 in MEMWB.
  - STR Instr=0xE5802004 → States 0,1,2,5. MemWrite=1 only in MEMWRITE. RegSrc=10.
- **CMP:** Instr=0xE3500000 with ALUFlags=0100 → States 0,1,7,0. ALUControl=01. Flags=0100. RegWrite is never 1.
- **Reset mid-op and Rd=15:**
  - Assert reset during MEMWRITE → MemWrite=0 that cycle; next State=0.
  - ADD with Rd=15 (0xE28FF004) → PCWrite=1 and RegWrite=1 in ALUWB.
